// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32I core: forward selects, ALU ops,
// result-select encodings and the bundled ID/EX control word.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // All E-stage control fields in one word, so a bubble is simply '0.
  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [1:0] result_src;
  } id_ex_ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Forward-source selection for one E-stage operand. M wins over W;
// x0 is never forwarded.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  // Priority compare: younger (M) result first, then W, else register file.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Build option: define ID_EX_FWD_EN to enable M/W forwarding; without it
// the ALU operands come straight from the registered register-file reads.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EnE,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [2:0]        ALUControlD,
  input  logic              ALUSrcAD,
  input  logic              ALUSrcBD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic [1:0]        ResultSrcD,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [XLEN-1:0]   ResultW,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   SrcA0E,
  output logic [XLEN-1:0]   SrcB0E,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [REG_AW-1:0] RdE,
  output logic [2:0]        ALUControlE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic [1:0]        ResultSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              LoadStallD
);

  id_ex_ctrl_t       ctrl_d;
  id_ex_ctrl_t       ctrl_e;
  logic [XLEN-1:0]   rd1_e;
  logic [XLEN-1:0]   rd2_e;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;

  assign ctrl_d = '{alu_control: ALUControlD, alu_src_a: ALUSrcAD,
                    alu_src_b: ALUSrcBD, reg_write: RegWriteD,
                    mem_write: MemWriteD, jump: JumpD, branch: BranchD,
                    result_src: ResultSrcD};

  // Pipeline register: flush beats enable; a bubble is all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCE     <= '0;
      ImmExtE <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      RdE     <= '0;
      ctrl_e  <= '0;
    end else if (FlushE) begin
      PCE     <= '0;
      ImmExtE <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      RdE     <= '0;
      ctrl_e  <= '0;
    end else if (EnE) begin
      PCE     <= PCD;
      ImmExtE <= ImmExtD;
      rd1_e   <= RD1D;
      rd2_e   <= RD2D;
      rs1_e   <= Rs1D;
      rs2_e   <= Rs2D;
      RdE     <= RdD;
      ctrl_e  <= ctrl_d;
    end
  end

  assign ALUControlE = ctrl_e.alu_control;
  assign ALUSrcAE    = ctrl_e.alu_src_a;
  assign ALUSrcBE    = ctrl_e.alu_src_b;
  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign JumpE       = ctrl_e.jump;
  assign BranchE     = ctrl_e.branch;
  assign ResultSrcE  = ctrl_e.result_src;

`ifdef ID_EX_FWD_EN
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  // Operand muxes driven by the forward selects.
  always_comb begin
    case (fwd_a)
      FWD_M:   SrcA0E = ALUResultM;
      FWD_W:   SrcA0E = ResultW;
      default: SrcA0E = rd1_e;
    endcase
    case (fwd_b)
      FWD_M:   SrcB0E = ALUResultM;
      FWD_W:   SrcB0E = ResultW;
      default: SrcB0E = rd2_e;
    endcase
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
`else
  logic unused_fwd_inputs;

  assign SrcA0E    = rd1_e;
  assign SrcB0E    = rd2_e;
  assign ForwardAE = FWD_RF;
  assign ForwardBE = FWD_RF;
  // Source addresses and M/W inputs only matter when forwarding is built in.
  assign unused_fwd_inputs = ^{ALUResultM, RdM, RdW, RegWriteM, RegWriteW,
                               ResultW, rs1_e, rs2_e};
`endif

  assign WriteDataE = SrcB0E;

  // The load in E cannot supply its data in time for a dependent op in D.
  assign LoadStallD = (ctrl_e.result_src == RESULT_SRC_LOAD) && ctrl_e.reg_write &&
                      (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Forwarding expectations follow the
// ID_EX_FWD_EN build option.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        EnE, FlushE;
  logic [31:0] PCD, RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, JumpD, BranchD;
  logic [1:0]  ResultSrcD;
  logic [31:0] ALUResultM, ResultW;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] PCE, ImmExtE, SrcA0E, SrcB0E, WriteDataE;
  logic [4:0]  RdE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcAE, ALUSrcBE, RegWriteE, MemWriteE, JumpE, BranchE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic        LoadStallD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .EnE(EnE), .FlushE(FlushE),
    .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ResultSrcD(ResultSrcD), .ALUResultM(ALUResultM), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultW(ResultW),
    .PCE(PCE), .ImmExtE(ImmExtE), .SrcA0E(SrcA0E), .SrcB0E(SrcB0E),
    .WriteDataE(WriteDataE), .RdE(RdE), .ALUControlE(ALUControlE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .LoadStallD(LoadStallD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".PCE"}, PCE, 32'h0);
    check({tag, ".ImmExtE"}, ImmExtE, 32'h0);
    check({tag, ".SrcA0E"}, SrcA0E, 32'h0);
    check({tag, ".SrcB0E"}, SrcB0E, 32'h0);
    check({tag, ".WriteDataE"}, WriteDataE, 32'h0);
    check({tag, ".RdE"}, {27'b0, RdE}, 32'h0);
    check({tag, ".ALUControlE"}, {29'b0, ALUControlE}, 32'h0);
    check({tag, ".ctrl"}, {26'b0, ALUSrcAE, ALUSrcBE, RegWriteE, MemWriteE, JumpE, BranchE}, 32'h0);
    check({tag, ".ResultSrcE"}, {30'b0, ResultSrcE}, 32'h0);
  endtask

  task automatic set_d(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] rd, input logic [2:0] aluc, input logic [5:0] c,
                       input logic [1:0] rsrc);
    PCD = pc; RD1D = r1; RD2D = r2; ImmExtD = imm;
    Rs1D = s1; Rs2D = s2; RdD = rd; ALUControlD = aluc;
    {ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, JumpD, BranchD} = c;
    ResultSrcD = rsrc;
  endtask

  initial begin
    rst = 1'b1; EnE = 1'b1; FlushE = 1'b0;
    ALUResultM = '0; ResultW = '0; RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    set_d(32'h0000_1000, 32'h1234_5678, 32'h0BAD_F00D, 32'h0000_0044, 5'd1, 5'd2, 5'd3,
          3'b010, 6'b111111, 2'b01);

    // Reset held across an edge with nonzero D inputs.
    step();
    check_zero("rst_hold");

    // First capture at the first edge with rst low.
    rst = 1'b0;
    step();
    check("cap.SrcA0E", SrcA0E, 32'h1234_5678);
    check("cap.PCE", PCE, 32'h0000_1000);
    check("cap.RdE", {27'b0, RdE}, 32'd3);
    check("cap.ctrl", {26'b0, ALUSrcAE, ALUSrcBE, RegWriteE, MemWriteE, JumpE, BranchE}, 32'h3F);

    // Asynchronous reset mid-cycle clears outputs without an edge.
    #2 rst = 1'b1;
    #1;
    check_zero("rst_async");
    rst = 1'b0;
    step();
    check("recap.SrcA0E", SrcA0E, 32'h1234_5678);
    check("recap.SrcB0E", SrcB0E, 32'h0BAD_F00D);

    // Capture a reference vector, then stall for 3 cycles with changed D inputs.
    set_d(32'h0000_0100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd4, 3'b101, 6'b101010, 2'b10);
    step();
    set_d(32'hFFFF_FFFF, 32'hEE, 32'hDD, 32'hCC, 5'd9, 5'd10, 5'd11, 3'b111, 6'b010101, 2'b11);
    EnE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.PCE", PCE, 32'h100);
      check("stall.SrcA0E", SrcA0E, 32'h11);
      check("stall.SrcB0E", SrcB0E, 32'h22);
      check("stall.ImmExtE", ImmExtE, 32'h33);
      check("stall.RdE", {27'b0, RdE}, 32'd4);
      check("stall.ALUControlE", {29'b0, ALUControlE}, 32'd5);
      check("stall.ctrl", {26'b0, ALUSrcAE, ALUSrcBE, RegWriteE, MemWriteE, JumpE, BranchE}, 32'h2A);
      check("stall.ResultSrcE", {30'b0, ResultSrcE}, 32'd2);
    end

    // Flush overrides enable.
    EnE = 1'b1; FlushE = 1'b1;
    set_d(32'h200, 32'h55, 32'h66, 32'h77, 5'd3, 5'd4, 5'd9, 3'b011, 6'b001000, 2'b00);
    step();
    FlushE = 1'b0;
    check("flush.RegWriteE", {31'b0, RegWriteE}, 32'd0);
    check("flush.RdE", {27'b0, RdE}, 32'd0);
    check("flush.PCE", PCE, 32'h0);
    check("flush.ALUControlE", {29'b0, ALUControlE}, 32'd0);

    // M has priority over W on operand A.
    set_d(32'h300, 32'h1111, 32'h2222, 32'h0, 5'd5, 5'd6, 5'd8, 3'b000, 6'b001000, 2'b00);
    step();
    RdM = 5'd5; RegWriteM = 1'b1; ALUResultM = 32'hAAAA_0000;
    RdW = 5'd5; RegWriteW = 1'b1; ResultW = 32'h0000_5555;
    #1;
    check("mprio.ForwardAE", {30'b0, ForwardAE}, FWD ? 32'd2 : 32'd0);
    check("mprio.SrcA0E", SrcA0E, FWD ? 32'hAAAA_0000 : 32'h1111);
    check("mprio.ForwardBE", {30'b0, ForwardBE}, 32'd0);
    check("mprio.SrcB0E", SrcB0E, 32'h2222);
    // Drop M write enable: W takes over.
    RegWriteM = 1'b0;
    #1;
    check("wfallback.ForwardAE", {30'b0, ForwardAE}, FWD ? 32'd1 : 32'd0);
    check("wfallback.SrcA0E", SrcA0E, FWD ? 32'h5555 : 32'h1111);

    // W forward on B with a non-matching M.
    set_d(32'h400, 32'h8888, 32'h7777, 32'h0, 5'd8, 5'd7, 5'd2, 3'b000, 6'b001000, 2'b00);
    step();
    RdM = 5'd9; RegWriteM = 1'b1; ALUResultM = 32'hDEAD_BEEF;
    RdW = 5'd7; RegWriteW = 1'b1; ResultW = 32'h42;
    #1;
    check("wfwdb.ForwardBE", {30'b0, ForwardBE}, FWD ? 32'd1 : 32'd0);
    check("wfwdb.SrcB0E", SrcB0E, FWD ? 32'h42 : 32'h7777);
    check("wfwdb.WriteDataE", WriteDataE, FWD ? 32'h42 : 32'h7777);
    check("wfwdb.ForwardAE", {30'b0, ForwardAE}, 32'd0);
    check("wfwdb.SrcA0E", SrcA0E, 32'h8888);
    // While stalled the forwarded operand still follows W.
    EnE = 1'b0;
    step();
    ResultW = 32'h43;
    #1;
    check("stallfwd.SrcB0E", SrcB0E, FWD ? 32'h43 : 32'h7777);
    check("stallfwd.PCE", PCE, 32'h400);
    EnE = 1'b1;

    // x0 is never forwarded.
    set_d(32'h500, 32'h99, 32'hAB, 32'h0, 5'd0, 5'd0, 5'd1, 3'b000, 6'b000000, 2'b00);
    step();
    RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hDEAD_0000;
    RdW = 5'd0; RegWriteW = 1'b1; ResultW = 32'hBEEF_0000;
    #1;
    check("x0.ForwardAE", {30'b0, ForwardAE}, 32'd0);
    check("x0.SrcA0E", SrcA0E, 32'h99);
    check("x0.ForwardBE", {30'b0, ForwardBE}, 32'd0);
    check("x0.SrcB0E", SrcB0E, 32'hAB);
    RegWriteM = 1'b0; RegWriteW = 1'b0;

    // Load-use detection against the instruction now in D.
    set_d(32'h600, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 3'b000, 6'b001000, 2'b01);
    step();
    Rs1D = 5'd4; Rs2D = 5'd3; EnE = 1'b0;
    #1;
    check("lu.rs2", {31'b0, LoadStallD}, 32'd1);
    Rs2D = 5'd5;
    #1;
    check("lu.nomatch", {31'b0, LoadStallD}, 32'd0);
    Rs1D = 5'd3;
    #1;
    check("lu.rs1", {31'b0, LoadStallD}, 32'd1);
    EnE = 1'b1;
    // Load to x0 never stalls.
    set_d(32'h700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 3'b000, 6'b001000, 2'b01);
    step();
    Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    check("lu.rd0", {31'b0, LoadStallD}, 32'd0);
    // Non-load writer to the same register does not stall.
    set_d(32'h800, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 3'b000, 6'b001000, 2'b00);
    step();
    Rs1D = 5'd3;
    #1;
    check("lu.notload", {31'b0, LoadStallD}, 32'd0);

    // Reset in the middle of a stall.
    set_d(32'h900, 32'h5A, 32'hA5, 32'h1, 5'd1, 5'd2, 5'd6, 3'b001, 6'b111111, 2'b01);
    step();
    EnE = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check_zero("rst_stall");
    rst = 1'b0;
    step();
    check("post_rst_stall.PCE", PCE, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
